// File: rtl/gif_playback_ctrl_if.sv
// rtl/gif_playback_ctrl_if.sv - signal bundle between the GIF screen sequencer and its surroundings
interface gif_playback_ctrl_if #(
    parameter int FIDX_W = 3
);
    logic              framebufferClk;
    logic              enable;
    logic              touch_valid;
    logic [8:0]        touch_x;
    logic [8:0]        touch_y;
    logic              quit_ack;
    logic [8:0]        game_x;
    logic [8:0]        game_y;
    logic              frame_start;
    logic [FIDX_W-1:0] frame_idx;
    logic              playing;
    logic              quit_req;

    modport master (
        output framebufferClk, enable, touch_valid, touch_x, touch_y, quit_ack,
        input  game_x, game_y, frame_start, frame_idx, playing, quit_req
    );

    modport slave (
        input  framebufferClk, enable, touch_valid, touch_x, touch_y, quit_ack,
        output game_x, game_y, frame_start, frame_idx, playing, quit_req
    );
endinterface

// File: rtl/gif_playback_ctrl.sv
// rtl/gif_playback_ctrl.sv - GIF screen sequencer: scan tracking, frame stepping, play/pause and quit
module gif_playback_ctrl #(
    parameter int LCD_W       = 240,
    parameter int LCD_H       = 320,
    parameter int NUM_FRAMES  = 8,
    parameter int FIDX_W      = 3,
    parameter int FRAME_DELAY = 6,
    parameter int QUIT_X0     = 120,
    parameter int QUIT_X1     = 200,
    parameter int QUIT_Y0     = 10,
    parameter int QUIT_Y1     = 40,
    parameter int BOX_X0      = 0,
    parameter int BOX_X1      = 319,
    parameter int BOX_Y0      = 50,
    parameter int BOX_Y1      = 229
) (
    input  logic                clk,
    input  logic                reset_n,
    gif_playback_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_PLAY, S_PAUSE, S_QUIT} state_t;

    localparam int DCNT_W = (FRAME_DELAY > 1) ? $clog2(FRAME_DELAY) : 1;

    localparam logic [8:0]        X_LAST    = 9'(LCD_W - 1);
    localparam logic [8:0]        Y_LAST    = 9'(LCD_H - 1);
    localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(FRAME_DELAY - 1);
    localparam logic [8:0]        QX0 = 9'(QUIT_X0);
    localparam logic [8:0]        QX1 = 9'(QUIT_X1);
    localparam logic [8:0]        QY0 = 9'(QUIT_Y0);
    localparam logic [8:0]        QY1 = 9'(QUIT_Y1);
    localparam logic [8:0]        BX0 = 9'(BOX_X0);
    localparam logic [8:0]        BX1 = 9'(BOX_X1);
    localparam logic [8:0]        BY0 = 9'(BOX_Y0);
    localparam logic [8:0]        BY1 = 9'(BOX_Y1);

    // Inclusive range test; a value below lo wraps to a large offset and fails.
    function automatic logic in_range(input logic [8:0] v, input logic [8:0] lo,
                                      input logic [8:0] hi);
        return 9'(v - lo) <= 9'(hi - lo);
    endfunction

    logic [8:0]        scan_x;
    logic [8:0]        scan_y;
    logic              fbclk_d;
    logic              touch_d;
    logic              frame_start_q;
    state_t            state;
    state_t            state_nx;
    logic [FIDX_W-1:0] frame_idx;
    logic [FIDX_W-1:0] fidx_nx;
    logic [DCNT_W-1:0] delay_cnt;
    logic [DCNT_W-1:0] dcnt_nx;

    logic fb_rise;
    logic scan_wrap;
    logic press;
    logic hit_quit;
    logic hit_box;

    assign fb_rise   = bus.framebufferClk & ~fbclk_d;
    assign scan_wrap = fb_rise && (scan_x == X_LAST) && (scan_y == Y_LAST);
    assign press     = bus.touch_valid & ~touch_d;
    assign hit_quit  = press && in_range(bus.touch_x, QX0, QX1) && in_range(bus.touch_y, QY0, QY1);
    assign hit_box   = press && !hit_quit
                       && in_range(bus.touch_x, BX0, BX1) && in_range(bus.touch_y, BY0, BY1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_x        <= '0;
            scan_y        <= '0;
            fbclk_d       <= 1'b0;
            touch_d       <= 1'b0;
            frame_start_q <= 1'b0;
            state         <= S_IDLE;
            frame_idx     <= '0;
            delay_cnt     <= '0;
        end else begin
            fbclk_d       <= bus.framebufferClk;
            touch_d       <= bus.touch_valid;
            frame_start_q <= scan_wrap;
            if (fb_rise) begin
                if (scan_x == X_LAST) begin
                    scan_x <= '0;
                    scan_y <= (scan_y == Y_LAST) ? 9'd0 : scan_y + 9'd1;
                end else begin
                    scan_x <= scan_x + 9'd1;
                end
            end
            state     <= state_nx;
            frame_idx <= fidx_nx;
            delay_cnt <= dcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        fidx_nx  = frame_idx;
        dcnt_nx  = delay_cnt;
        case (state)
            S_IDLE:  if (bus.enable) state_nx = S_ARM;
            S_ARM:   if (frame_start_q) state_nx = S_PLAY;
            S_PLAY: begin
                if (frame_start_q) begin
                    if (delay_cnt == DCNT_LAST) begin
                        dcnt_nx = '0;
                        fidx_nx = (frame_idx == FIDX_LAST) ? '0 : frame_idx + FIDX_W'(1);
                    end else begin
                        dcnt_nx = delay_cnt + DCNT_W'(1);
                    end
                end
                if (hit_quit)     state_nx = S_QUIT;
                else if (hit_box) state_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (hit_quit)     state_nx = S_QUIT;
                else if (hit_box) state_nx = S_PLAY;
            end
            S_QUIT:  if (bus.quit_ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // The quit handshake must finish before a disable can take effect.
        if (!bus.enable && state != S_QUIT) state_nx = S_IDLE;
        if (state_nx == S_IDLE) begin
            fidx_nx = '0;
            dcnt_nx = '0;
        end
    end

    assign bus.game_x      = scan_y;
    assign bus.game_y      = X_LAST - scan_x;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_idx   = frame_idx;
    assign bus.playing     = (state == S_PLAY);
    assign bus.quit_req    = (state == S_QUIT);

endmodule

// File: tb/tb_gif_playback_ctrl.sv
// tb/tb_gif_playback_ctrl.sv - directed self-checking bench for gif_playback_ctrl on a reduced 8x6 panel
module tb_gif_playback_ctrl;
    localparam int LW = 8;
    localparam int LH = 6;
    localparam int NF = 8;
    localparam int FD = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    gif_playback_ctrl_if #(.FIDX_W(3)) ifc ();

    gif_playback_ctrl #(
        .LCD_W(LW), .LCD_H(LH), .NUM_FRAMES(NF), .FIDX_W(3), .FRAME_DELAY(FD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int mx = 0;
    int my = 0;
    int m_idx = 0;
    int m_dly = 0;
    bit m_play = 0;
    bit m_arm = 0;
    bit last_fs = 0;

    // One framebufferClk rise; the scan model steps with it and the FSM model tracks frame_start.
    task automatic fb_pulse(input bit do_touch, input logic [8:0] tx, input logic [8:0] ty);
        bit exp_fs;
        exp_fs = (mx == LW - 1) && (my == LH - 1);
        ifc.framebufferClk = 1'b1;
        @(posedge clk); #1;
        ifc.framebufferClk = 1'b0;
        if (do_touch) begin
            ifc.touch_x = tx;
            ifc.touch_y = ty;
            ifc.touch_valid = 1'b1;
        end
        if (mx == LW - 1) begin
            mx = 0;
            my = (my == LH - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        @(negedge clk);
        total++;
        if (ifc.frame_start !== exp_fs) begin
            bad++;
            $display("FAIL frame_start: got %b want %b at scan (%0d,%0d)", ifc.frame_start, exp_fs, mx, my);
        end
        total++;
        if (ifc.game_x !== 9'(my) || ifc.game_y !== 9'(LW - 1 - mx)) begin
            bad++;
            $display("FAIL game_xy: got (%0d,%0d) want (%0d,%0d)", ifc.game_x, ifc.game_y, my, LW - 1 - mx);
        end
        total++;
        if (ifc.frame_idx !== 3'(m_idx)) begin
            bad++;
            $display("FAIL frame_idx_hold: got %0d want %0d", ifc.frame_idx, m_idx);
        end
        if (exp_fs && m_play) begin
            if (m_dly == FD - 1) begin
                m_dly = 0;
                m_idx = (m_idx == NF - 1) ? 0 : m_idx + 1;
            end else begin
                m_dly = m_dly + 1;
            end
        end
        if (exp_fs && m_arm) begin
            m_arm = 0;
            m_play = 1;
        end
        if (do_touch) m_play = 0;
        @(posedge clk); #1;
        total++;
        if (ifc.frame_start !== 1'b0 || ifc.playing !== m_play) begin
            bad++;
            $display("FAIL pulse_tail: got fs=%b playing=%b want fs=0 playing=%b", ifc.frame_start, ifc.playing, m_play);
        end
        total++;
        if (ifc.frame_idx !== 3'(m_idx)) begin
            bad++;
            $display("FAIL frame_idx: got %0d want %0d", ifc.frame_idx, m_idx);
        end
        last_fs = exp_fs;
    endtask

    task automatic run_frames(input int n);
        repeat (n * LW * LH) fb_pulse(1'b0, 9'd0, 9'd0);
    endtask

    task automatic press(input logic [8:0] tx, input logic [8:0] ty);
        ifc.touch_x = tx;
        ifc.touch_y = ty;
        ifc.touch_valid = 1'b1;
        @(posedge clk); #1;
        ifc.touch_valid = 1'b0;
    endtask

    task automatic test_reset;
        ifc.framebufferClk = 1'b0;
        ifc.enable = 1'b0;
        ifc.touch_valid = 1'b0;
        ifc.touch_x = '0;
        ifc.touch_y = '0;
        ifc.quit_ack = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (ifc.game_x !== 9'd0 || ifc.game_y !== 9'd7) begin
            bad++;
            $display("FAIL reset_game: got (%0d,%0d) want (0,7)", ifc.game_x, ifc.game_y);
        end
        total++;
        if (ifc.frame_start !== 1'b0 || ifc.quit_req !== 1'b0 || ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got fs=%b quit=%b play=%b want 0 0 0", ifc.frame_start, ifc.quit_req, ifc.playing);
        end
        total++;
        if (ifc.frame_idx !== 3'd0) begin
            bad++;
            $display("FAIL reset_idx: got %0d want 0", ifc.frame_idx);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_arm_first_frame;
        ifc.enable = 1'b1;
        @(posedge clk); #1;
        m_arm = 1;
        repeat (LW * LH - 1) fb_pulse(1'b0, 9'd0, 9'd0);
        total++;
        if (ifc.game_x !== 9'd5 || ifc.game_y !== 9'd0 || ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL scan_corner: got (%0d,%0d) play=%b want (5,0) play=0", ifc.game_x, ifc.game_y, ifc.playing);
        end
        fb_pulse(1'b0, 9'd0, 9'd0);
        total++;
        if (!last_fs || ifc.playing !== 1'b1) begin
            bad++;
            $display("FAIL first_frame: got playing=%b want 1 after %0d rises", ifc.playing, LW * LH);
        end
    endtask

    task automatic test_frame_advance;
        run_frames(6);
        total++;
        if (ifc.frame_idx !== 3'd1) begin
            bad++;
            $display("FAIL advance_6: got %0d want 1", ifc.frame_idx);
        end
        run_frames(41);
        total++;
        if (ifc.frame_idx !== 3'd7) begin
            bad++;
            $display("FAIL advance_47: got %0d want 7", ifc.frame_idx);
        end
        run_frames(1);
        total++;
        if (ifc.frame_idx !== 3'd0) begin
            bad++;
            $display("FAIL wrap_48: got %0d want 0", ifc.frame_idx);
        end
    endtask

    task automatic test_pause;
        run_frames(2);
        ifc.touch_x = 9'd160;
        ifc.touch_y = 9'd120;
        ifc.touch_valid = 1'b1;
        @(posedge clk); #1;
        m_play = 0;
        total++;
        if (ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL pause_enter: got playing=%b want 0", ifc.playing);
        end
        run_frames(3);
        total++;
        if (ifc.frame_idx !== 3'd0 || ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL pause_hold: got idx=%0d play=%b want 0 0", ifc.frame_idx, ifc.playing);
        end
        ifc.touch_valid = 1'b0;
        @(posedge clk); #1;
        press(9'd160, 9'd120);
        m_play = 1;
        total++;
        if (ifc.playing !== 1'b1) begin
            bad++;
            $display("FAIL resume: got playing=%b want 1", ifc.playing);
        end
        run_frames(3);
        total++;
        if (ifc.frame_idx !== 3'd0) begin
            bad++;
            $display("FAIL resume_dly: got %0d want 0", ifc.frame_idx);
        end
        run_frames(1);
        total++;
        if (ifc.frame_idx !== 3'd1) begin
            bad++;
            $display("FAIL resume_adv: got %0d want 1", ifc.frame_idx);
        end
    endtask

    task automatic quit_ack_pulse;
        ifc.touch_valid = 1'b0;
        ifc.quit_ack = 1'b1;
        @(posedge clk); #1;
        ifc.quit_ack = 1'b0;
        total++;
        if (ifc.quit_req !== 1'b0 || ifc.frame_idx !== 3'd0 || ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL quit_ack: got quit=%b idx=%0d play=%b want 0 0 0", ifc.quit_req, ifc.frame_idx, ifc.playing);
        end
        m_idx = 0;
        m_dly = 0;
        m_play = 0;
        @(posedge clk); #1;
        m_arm = 1;
    endtask

    task automatic test_quit;
        press(9'd150, 9'd20);
        m_play = 0;
        total++;
        if (ifc.quit_req !== 1'b1 || ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL quit_enter: got quit=%b play=%b want 1 0", ifc.quit_req, ifc.playing);
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            total++;
            if (ifc.quit_req !== 1'b1) begin
                bad++;
                $display("FAIL quit_held: got %b want 1 at clk %0d", ifc.quit_req, i);
            end
        end
        press(9'd160, 9'd120);
        total++;
        if (ifc.quit_req !== 1'b1 || ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL quit_ignores_touch: got quit=%b play=%b want 1 0", ifc.quit_req, ifc.playing);
        end
        quit_ack_pulse();
        run_frames(1);
    endtask

    task automatic test_quit_at_frame_start;
        run_frames(5);
        repeat (LW * LH - 1) fb_pulse(1'b0, 9'd0, 9'd0);
        fb_pulse(1'b1, 9'd150, 9'd20);
        total++;
        if (ifc.frame_idx !== 3'd1 || ifc.quit_req !== 1'b1) begin
            bad++;
            $display("FAIL quit_at_fs: got idx=%0d quit=%b want 1 1", ifc.frame_idx, ifc.quit_req);
        end
        quit_ack_pulse();
    endtask

    task automatic test_enable_drop;
        run_frames(1);
        run_frames(18);
        total++;
        if (ifc.frame_idx !== 3'd3 || ifc.playing !== 1'b1) begin
            bad++;
            $display("FAIL pre_drop: got idx=%0d play=%b want 3 1", ifc.frame_idx, ifc.playing);
        end
        repeat (20) fb_pulse(1'b0, 9'd0, 9'd0);
        ifc.enable = 1'b0;
        @(posedge clk); #1;
        m_play = 0;
        m_idx = 0;
        m_dly = 0;
        total++;
        if (ifc.playing !== 1'b0 || ifc.frame_idx !== 3'd0) begin
            bad++;
            $display("FAIL drop: got play=%b idx=%0d want 0 0", ifc.playing, ifc.frame_idx);
        end
        ifc.enable = 1'b1;
        @(posedge clk); #1;
        m_arm = 1;
        repeat (LW * LH - 21) fb_pulse(1'b0, 9'd0, 9'd0);
        total++;
        if (ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL rearm_wait: got play=%b want 0", ifc.playing);
        end
        fb_pulse(1'b0, 9'd0, 9'd0);
        total++;
        if (ifc.playing !== 1'b1 || ifc.frame_idx !== 3'd0) begin
            bad++;
            $display("FAIL rearm_play: got play=%b idx=%0d want 1 0", ifc.playing, ifc.frame_idx);
        end
    endtask

    task automatic test_async_reset;
        repeat (10) fb_pulse(1'b0, 9'd0, 9'd0);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (ifc.game_x !== 9'd0 || ifc.game_y !== 9'd7 || ifc.playing !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got (%0d,%0d) play=%b want (0,7) 0", ifc.game_x, ifc.game_y, ifc.playing);
        end
    endtask

    initial begin
        test_reset();
        test_arm_first_frame();
        test_frame_advance();
        test_pause();
        test_quit();
        test_quit_at_frame_start();
        test_enable_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
